mul_arbiter: RTL
================

# mul_arbiter

Sequencer and two-way arbiter for the shared shift-add multiplier in the MIPS CPU multiply path. It accepts multiply requests from two clients (requester 0: integer MULT/MULTU unit, requester 1: address/debug client). It grants them round-robin and latches their operands. It launches the multiplier with a one-cycle start pulse, waits for completion or timeout, and returns the registered product with a one-cycle acknowledge.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH.
- TMO, 255, maximum cycles spent in WAIT before abort; must be ≥ 2*WIDTH+2.

- Clk  in  1  clock, all logic on rising edge
- Reset_n  in  1  reset, synchronous, active-low
- Req0, Req1  in  1  request; held high with operands stable until matching Ack
- A0, B0, A1, B1  in  WIDTH  multiplicand / multiplier per requester
- Ack0, Ack1  out  1  one-cycle completion pulse
- Result0, Result1  out  2*WIDTH  product, valid in Ack cycle, held until next Ack to same requester
- Err0, Err1  out  1  valid with Ack; 1 = aborted by timeout
- Busy  out  1  state ≠ IDLE
- Err_flag  out  1  sticky: any timeout since reset
- Mul_St  out  1  start pulse to multiplier
- Mul_Mcand, Mul_Mplier  out  WIDTH  latched operands
- Mul_Rst  out  1  active-high reset to multiplier
- Mul_Idle, Mul_Done  in  1  multiplier status
- Mul_Product  in  2*WIDTH  multiplier result

## Operation
- States: IDLE, START, WAIT, RESP (2-bit register).
- IDLE: if (Req0|Req1) && Mul_Idle → choose grantee, latch A/B of grantee into operand registers, record grantee, → START. Otherwise stay.
- Arbitration: pointer `last` = last requester acked (reset value 1, so requester 0 wins first). Single request is granted directly. With both requesting, the grant goes to ~last.
- START: Mul_St=1 for exactly this cycle; clear timeout counter; → WAIT.
- WAIT: counter increments each cycle. If Mul_Done=1: capture Mul_Product into grantee's Result register, Err=0, → RESP. Else if counter == TMO: Result of grantee ← 0, Err ← 1, Err_flag ← 1, Mul_Rst=1 for one cycle, → RESP. Mul_Done takes priority over timeout in the same cycle.
- RESP: Ack of grantee =1, other Ack 0; `last` ← grantee; → IDLE.
- Mul_Mcand/Mul_Mplier drive latched registers at all times; they change only on an IDLE→START transition.
- Req dropped mid-operation is ignored; the operation completes and Ack is still issued.
- Req still high in cycle after Ack counts as a new request.
- Mul_Rst = ~Reset_n | timeout pulse (registered pulse, combinational OR with reset).

## Timing
- Reset (Reset_n=0 at edge): state IDLE, Ack0=Ack1=0, Result0=Result1=0, Err0=Err1=0, Err_flag=0, Busy=0, Mul_St=0, operand registers 0, counter 0, `last`=1. Mul_Rst=1 while Reset_n=0. Reset mid-operation aborts without Ack.
- Req sampled high in IDLE at edge k → START (Mul_St=1) during cycle k+1 → WAIT from k+2.
- Mul_Done=1 in cycle d → Ack/Result in cycle d+1 → IDLE at d+2. Earliest next Mul_St: d+3.
- With multiplier taking 2*WIDTH cycles plus Done, Req-to-Ack = 2*WIDTH+4 cycles.
- Busy is high from START through RESP inclusive.
- Mul_Idle=0 in IDLE (e.g. after abort) blocks grants; no request is lost.

## Test plan
- Req0=1, A0=7, B0=9, WIDTH=16 → exactly one Mul_St pulse; Ack0 one cycle with Result0=63, Err0=0; Ack1 never asserted.
- Req0 and Req1 raised together after reset (A0=3,B0=5; A1=4,B1=6), held until ack → Ack0 first (Result0=15), then Ack1 (Result1=24); next simultaneous pair serves 0 again only after 1.
- A0=16'hFFFF, B0=16'hFFFF → Result0=32'hFFFE0001.
- TMO=40, multiplier model never asserts Mul_Done → at 40th WAIT cycle Mul_Rst pulse, next cycle Ack0 with Err0=1, Result0=0; Err_flag stays 1 until reset.
- Reset_n=0 for one cycle while in WAIT → next cycle all outputs at reset values, no Ack; fresh Req1 then completes normally.
- Req0 dropped one cycle after grant → operation still completes with Ack0 and correct Result0; no second Mul_St.

Source files
------------

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sequencer granting two clients the shared shift-add multiplier,
// launching it, waiting for completion or timeout and returning the registered product.
module mul_arbiter #(
    parameter int WIDTH = 16,
    parameter int TMO   = 255
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Req0,
    input  logic               Req1,
    input  logic [WIDTH-1:0]   A0,
    input  logic [WIDTH-1:0]   B0,
    input  logic [WIDTH-1:0]   A1,
    input  logic [WIDTH-1:0]   B1,
    output logic               Ack0,
    output logic               Ack1,
    output logic [2*WIDTH-1:0] Result0,
    output logic [2*WIDTH-1:0] Result1,
    output logic               Err0,
    output logic               Err1,
    output logic               Busy,
    output logic               Err_flag,
    output logic               Mul_St,
    output logic [WIDTH-1:0]   Mul_Mcand,
    output logic [WIDTH-1:0]   Mul_Mplier,
    output logic               Mul_Rst,
    input  logic               Mul_Idle,
    input  logic               Mul_Done,
    input  logic [2*WIDTH-1:0] Mul_Product
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
    localparam int CW = $clog2(TMO + 1);
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          grant, last, pick, grab, done_hit, tmo_hit, fin;
    // with both clients waiting, the one not served last wins
    assign pick     = (Req0 && Req1) ? ~last : Req1;
    assign grab     = state == IDLE && (Req0 || Req1) && Mul_Idle;
    assign done_hit = state == WAIT && Mul_Done;
    assign tmo_hit  = state == WAIT && !Mul_Done && cnt == CW'(TMO - 1);
    assign fin      = done_hit || tmo_hit;
    assign Busy     = state != IDLE;
    assign Mul_St   = state == START;
    assign Ack0     = state == RESP && !grant;
    assign Ack1     = state == RESP && grant;
    assign Mul_Rst  = !Reset_n || tmo_hit;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grab ? START : IDLE;
            START:   state_nxt = WAIT;
            WAIT:    state_nxt = fin ? RESP : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= 1'b0;
            last       <= 1'b1;
            Mul_Mcand  <= '0;
            Mul_Mplier <= '0;
            Result0    <= '0;
            Result1    <= '0;
            Err0       <= 1'b0;
            Err1       <= 1'b0;
            Err_flag   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (grab) begin
                grant      <= pick;
                Mul_Mcand  <= pick ? A1 : A0;
                Mul_Mplier <= pick ? B1 : B0;
            end
            if (fin && !grant) begin
                Result0 <= done_hit ? Mul_Product : '0;
                Err0    <= tmo_hit;
            end
            if (fin && grant) begin
                Result1 <= done_hit ? Mul_Product : '0;
                Err1    <= tmo_hit;
            end
            if (tmo_hit)
                Err_flag <= 1'b1;
            if (state == RESP)
                last <= grant;
        end
    end
endmodule
